// File: rtl/window_scan_ctrl.sv
// Raster scan controller: walks a COLS x ROWS window grid issuing line-memory reads,
// mirrors them as writes PIPE_LAT cycles later. Optional stall input enabled by SCAN_HOLD_EN.
module window_scan_ctrl #(
    parameter int COLS     = 256,
    parameter int ROWS     = 32,
    parameter int PIPE_LAT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       hold,
    output logic       rd,
    output logic       wr,
    output logic [7:0] col,
    output logic [4:0] row,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FIN} state_t;

    state_t              state;
    state_t              state_next;
    logic [PIPE_LAT-1:0] pipe;
    logic [PIPE_LAT-1:0] pipe_shift;
    logic                stall;
    logic                last_rd;
    logic                drained;

`ifdef SCAN_HOLD_EN
    assign stall = hold;
`else
    logic unused_hold;
    assign unused_hold = hold;
    assign stall       = 1'b0;
`endif

    assign last_rd    = (col == 8'(COLS - 1)) && (row == 5'(ROWS - 1));
    assign pipe_shift = pipe << 1;
    // rd is never issued in DRAIN, so the pipe is empty after this edge when only the MSB remains.
    assign drained    = (pipe_shift == '0);

    assign wr   = pipe[PIPE_LAT-1];
    assign busy = (state != IDLE);
    assign done = (state == FIN);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        state_next = state;
        rd         = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_next = SCAN;
            end
            SCAN: begin
                rd = !stall;
                if (!stall && last_rd) state_next = DRAIN;
            end
            DRAIN: begin
                if (drained) state_next = FIN;
            end
            FIN: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the delay line is reset so an abandoned strip cannot leak writes into the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe <= '0;
        end else begin
            pipe <= pipe_shift | PIPE_LAT'(rd);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (state == IDLE && start) begin
            col <= '0;
            row <= '0;
        end else if (rd && !last_rd) begin
            if (col == 8'(COLS - 1)) begin
                col <= '0;
                row <= row + 5'd1;
            end else begin
                col <= col + 8'd1;
            end
        end
    end

endmodule

// File: doc/window_scan_ctrl.md
WINDOW_SCAN_CTRL -- requirements
Module: window_scan_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 256, meaning output windows per row.
REQ-002 SHALL have parameter ROWS, default 32, meaning output rows per strip.
REQ-003 SHALL have parameter PIPE_LAT, default 2, range 1-15, meaning the number of cycles from rd to the matching pixelw at the line-memory write port.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  single-cycle strip start request.
REQ-007 SHALL have port hold  input  1  stall request; effective only with SCAN_HOLD_EN.
REQ-008 SHALL have port rd  output  1  window-read strobe to the line memory.
REQ-009 SHALL have port wr  output  1  result-write strobe to the line memory.
REQ-010 SHALL have port col  output  8  column index of the current rd.
REQ-011 SHALL have port row  output  5  row index of the current rd.
REQ-012 SHALL have port busy  output  1  high from the accepted start until done.
REQ-013 SHALL have port done  output  1  single-cycle strip-complete pulse.

Function
REQ-014 SHALL use FSM states IDLE, SCAN, DRAIN and FIN.
REQ-015 In IDLE, start=1 SHALL move the FSM to SCAN on the next edge with col=0, row=0 and busy=1.
REQ-016 In SCAN, rd SHALL be 1 every cycle that is not stalled, giving exactly COLS*ROWS rd cycles per strip.
REQ-017 Each rd cycle SHALL increment col; when col=COLS-1, col SHALL wrap to 0 and row SHALL increment.
REQ-018 The rd cycle at col=COLS-1, row=ROWS-1 SHALL be the last rd; the FSM SHALL then move to DRAIN, and col and row SHALL hold their final values.
REQ-019 wr SHALL equal rd delayed by exactly PIPE_LAT cycles, implemented as a PIPE_LAT-deep shift register that is cleared by reset.
REQ-020 The FSM SHALL stay in DRAIN until the shift register is empty, then move to FIN.
REQ-021 FIN SHALL last one cycle with done=1, then return to IDLE with busy=0.
REQ-022 The total wr count per strip SHALL equal the rd count (COLS*ROWS).
REQ-023 start SHALL be ignored in every state other than IDLE, with no restart and no effect on the counters.
REQ-024 start in the same cycle as FIN SHALL be ignored; a new strip SHALL require start while in IDLE.
REQ-025 In IDLE, rd SHALL be 0 and col and row SHALL keep their last values.

Reset
REQ-026 rst_n=0 SHALL immediately force: state IDLE, rd=0, wr=0, shift register cleared, col=0, row=0, busy=0, done=0.
REQ-027 Reset during SCAN or DRAIN SHALL abandon the strip with no further wr and no done pulse.
REQ-028 Reset deassertion SHALL take effect at the next clk edge; the first start is accepted at the earliest on the first edge after deassertion.

Configuration
REQ-029 With macro SCAN_HOLD_EN defined, hold=1 in SCAN SHALL force rd=0 and freeze col and row.
REQ-030 With SCAN_HOLD_EN defined, the shift register SHALL keep shifting during hold, so wr still drains in-flight reads.
REQ-031 With SCAN_HOLD_EN defined, hold SHALL have no effect in IDLE, DRAIN or FIN.
REQ-032 Without SCAN_HOLD_EN, hold SHALL be ignored and rd SHALL be continuous through SCAN.

Verification
REQ-033 Default parameters, start pulse at cycle 0 -> rd high for 8192 consecutive cycles; wr high for 8192 cycles starting 2 cycles after the first rd; done asserted exactly once, busy low one cycle after done.
REQ-034 COLS=4, ROWS=2 -> rd cycles with (row,col) in order (0,0)…(0,3),(1,0)…(1,3); col wraps 3->0 as row goes 0->1.
REQ-035 start re-pulsed mid-SCAN at rd number 100 -> rd count still 8192, with a single done.
REQ-036 rst_n low at rd number 5000 -> rd, wr, busy and done are 0 in the same cycle; no done follows; a new start gives a full 8192-rd strip.
REQ-037 SCAN_HOLD_EN defined, hold high for 10 cycles at rd number 300 -> 10-cycle gap in rd, col frozen, wr gap offset by PIPE_LAT, totals still 8192.
REQ-038 PIPE_LAT=15 -> last wr occurs 15 cycles after the last rd, done one cycle later.
